vexec_seq: RTL and testbench

Sequential vector execute stage sitting directly downstream of the vector register file: it consumes the two 5-lane source vectors read at ra1/ra2 and produces the 5-lane write-back bundle (we3, wa3, wd1..wd5) that feeds the register file's write port. A single shared 32-bit datapath processes one lane per cycle under a small FSM, trading throughput for area. Control issues work with a start pulse and stalls on busy.

---
 rtl/vexec_seq.sv | 216 +++++++++++++++++++++
 tb/tb_vexec_seq.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/vexec_seq.sv
// vexec_seq: sequential 5-lane x 32-bit vector execute stage, one lane per cycle.
// Optional DOT (op 101) multiply-accumulate path is built only when VEXEC_DOT_EN is defined.
module vexec_seq (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [3:0]   wa_in,
    input  logic [159:0] a_vec,
    input  logic [159:0] b_vec,
    output logic         vector_op,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic         zero,
    output logic         we3,
    output logic [3:0]   wa3,
    output logic [31:0]  wd1,
    output logic [31:0]  wd2,
    output logic [31:0]  wd3,
    output logic [31:0]  wd4,
    output logic [31:0]  wd5
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_ORR = 3'd3;
    localparam logic [2:0] OP_MUL = 3'd4;
    localparam logic [2:0] OP_DOT = 3'd5;

    function automatic logic op_legal(input logic [2:0] o);
        case (o)
            OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_MUL: op_legal = 1'b1;
`ifdef VEXEC_DOT_EN
            OP_DOT:                                 op_legal = 1'b1;
`endif
            default:                                op_legal = 1'b0;
        endcase
    endfunction

    state_t         state_r;
    state_t         state_next_s;
    logic [2:0]     op_r;
    logic [159:0]   a_r;
    logic [159:0]   b_r;
    logic [2:0]     cnt_r;
    logic [159:0]   res_r;
    logic [159:0]   wd_r;

    logic [31:0]    lane_a_s;
    logic [31:0]    lane_b_s;
    logic [31:0]    prod_s;
    logic [31:0]    lane_res_s;
    logic           legal_s;
    logic           write_lane_s;
    logic           last_lane_s;
    logic [159:0]   res_next_s;
    logic [159:0]   wd_final_s;
    logic           zero_final_s;
`ifdef VEXEC_DOT_EN
    logic [31:0]    acc_r;
    logic [31:0]    acc_next_s;
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = EXEC;
                end else begin
                    state_next_s = IDLE;
                end
            end
            EXEC: begin
                if (last_lane_s) begin
                    state_next_s = WB;
                end else begin
                    state_next_s = EXEC;
                end
            end
            WB:      state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Shared single-lane datapath and the write-back values formed on the last lane
    always_comb begin
        lane_a_s     = a_r[{cnt_r, 5'd0} +: 32];
        lane_b_s     = b_r[{cnt_r, 5'd0} +: 32];
        prod_s       = lane_a_s * lane_b_s;
        legal_s      = op_legal(op_r);
        last_lane_s  = (cnt_r == 3'd4);
        write_lane_s = legal_s && (op_r != OP_DOT);
        case (op_r)
            OP_ADD:  lane_res_s = lane_a_s + lane_b_s;
            OP_SUB:  lane_res_s = lane_a_s - lane_b_s;
            OP_AND:  lane_res_s = lane_a_s & lane_b_s;
            OP_ORR:  lane_res_s = lane_a_s | lane_b_s;
            OP_MUL:  lane_res_s = prod_s;
            default: lane_res_s = 32'd0;
        endcase
`ifdef VEXEC_DOT_EN
        acc_next_s = acc_r + prod_s;
`endif
        res_next_s = res_r;
        if (write_lane_s) begin
            res_next_s[{cnt_r, 5'd0} +: 32] = lane_res_s;
        end else begin
            res_next_s = res_r;
        end
        if (!legal_s) begin
            wd_final_s = 160'd0;
        end
`ifdef VEXEC_DOT_EN
        else if (op_r == OP_DOT) begin
            wd_final_s = {128'd0, acc_next_s};
        end
`endif
        else begin
            wd_final_s = res_next_s;
        end
        zero_final_s = legal_s && (wd_final_s == 160'd0);
    end

    // Operand latch, lane sequencing and registered write-back outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            op_r      <= 3'd0;
            a_r       <= 160'd0;
            b_r       <= 160'd0;
            cnt_r     <= 3'd0;
            res_r     <= 160'd0;
            wd_r      <= 160'd0;
            wa3       <= 4'd0;
            busy      <= 1'b0;
            vector_op <= 1'b0;
            done      <= 1'b0;
            we3       <= 1'b0;
            err       <= 1'b0;
            zero      <= 1'b0;
`ifdef VEXEC_DOT_EN
            acc_r     <= 32'd0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        op_r      <= op;
                        a_r       <= a_vec;
                        b_r       <= b_vec;
                        wa3       <= wa_in;
                        cnt_r     <= 3'd0;
                        res_r     <= 160'd0;
                        busy      <= 1'b1;
                        vector_op <= 1'b1;
`ifdef VEXEC_DOT_EN
                        acc_r     <= 32'd0;
`endif
                    end
                end
                EXEC: begin
                    res_r <= res_next_s;
                    cnt_r <= cnt_r + 3'd1;
`ifdef VEXEC_DOT_EN
                    if (op_r == OP_DOT) begin
                        acc_r <= acc_next_s;
                    end
`endif
                    // Outputs are loaded on the last lane so they are valid for the whole WB cycle
                    if (last_lane_s) begin
                        wd_r <= wd_final_s;
                        done <= 1'b1;
                        we3  <= legal_s;
                        err  <= !legal_s;
                        zero <= zero_final_s;
                    end
                end
                WB: begin
                    done      <= 1'b0;
                    we3       <= 1'b0;
                    busy      <= 1'b0;
                    vector_op <= 1'b0;
                end
                default: begin
                    done <= 1'b0;
                    we3  <= 1'b0;
                end
            endcase
        end
    end

    assign wd1 = wd_r[31:0];
    assign wd2 = wd_r[63:32];
    assign wd3 = wd_r[95:64];
    assign wd4 = wd_r[127:96];
    assign wd5 = wd_r[159:128];

endmodule

// File: tb/tb_vexec_seq.sv
// Scoreboard bench for vexec_seq: directed ops push expected write-back bundles,
// a negedge monitor pops and compares whenever done or we3 is seen.
module tb_vexec_seq;

    logic         clk;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [3:0]   wa_in;
    logic [159:0] a_vec;
    logic [159:0] b_vec;
    logic         vector_op;
    logic         busy;
    logic         done;
    logic         err;
    logic         zero;
    logic         we3;
    logic [3:0]   wa3;
    logic [31:0]  wd1, wd2, wd3, wd4, wd5;

    vexec_seq dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .wa_in(wa_in),
        .a_vec(a_vec), .b_vec(b_vec), .vector_op(vector_op), .busy(busy),
        .done(done), .err(err), .zero(zero), .we3(we3), .wa3(wa3),
        .wd1(wd1), .wd2(wd2), .wd3(wd3), .wd4(wd4), .wd5(wd5)
    );

    typedef struct {
        int           cyc;
        logic         we3;
        logic [3:0]   wa3;
        logic [159:0] wd;
        logic         zero;
        logic         err;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [159:0] pack5(input logic [31:0] l0, l1, l2, l3, l4);
        pack5 = {l4, l3, l2, l1, l0};
    endfunction

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Caller is at a negedge; drives a one-cycle start and queues the expected bundle
    task automatic issue(input logic [2:0] o, input logic [3:0] wa, input logic [159:0] a,
                         input logic [159:0] b, input logic e_we3, input logic [159:0] e_wd,
                         input logic e_zero, input logic e_err);
        exp_t e;
        op = o; wa_in = wa; a_vec = a; b_vec = b; start = 1'b1;
        e.cyc = cyc + 6; e.we3 = e_we3; e.wa3 = wa; e.wd = e_wd; e.zero = e_zero; e.err = e_err;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run(input logic [2:0] o, input logic [3:0] wa, input logic [159:0] a,
                       input logic [159:0] b, input logic e_we3, input logic [159:0] e_wd,
                       input logic e_zero, input logic e_err);
        @(negedge clk);
        issue(o, wa, a, b, e_we3, e_wd, e_zero, e_err);
        repeat (6) @(negedge clk);
    endtask

    // Monitor: every done or we3 must match the oldest queued expectation
    always @(negedge clk) begin
        if (done === 1'b1 || we3 === 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=%0b we3=%0b at cycle %0d, expected none", done, we3, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done_cycle", 160'(cyc), 160'(e.cyc));
                check("done", {159'd0, done}, 160'd1);
                check("busy_in_wb", {158'd0, busy, vector_op}, 160'd3);
                check("we3", {159'd0, we3}, {159'd0, e.we3});
                check("wa3", {156'd0, wa3}, {156'd0, e.wa3});
                check("wd", {wd5, wd4, wd3, wd2, wd1}, e.wd);
                check("zero", {159'd0, zero}, {159'd0, e.zero});
                check("err", {159'd0, err}, {159'd0, e.err});
            end
        end
    end

    task automatic check_all_zero(input string name);
        check(name, {wd5, wd4, wd3, wd2, wd1}, 160'd0);
        check(name, {152'd0, wa3, busy, vector_op, done, we3}, 160'd0);
        check(name, {158'd0, err, zero}, 160'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [159:0] v_a, v_b;
        reset = 1'b1; start = 1'b0; op = 3'd0; wa_in = 4'd0; a_vec = 160'd0; b_vec = 160'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_all_zero("reset_state");

        // ADD with busy sampled in cycle 1 and cycle 7
        @(negedge clk);
        issue(3'd0, 4'd3, pack5(1, 2, 3, 4, 5), pack5(10, 20, 30, 40, 50),
              1'b1, pack5(11, 22, 33, 44, 55), 1'b0, 1'b0);
        check("busy_cycle1", {158'd0, busy, vector_op}, 160'd3);
        repeat (6) @(negedge clk);
        check("busy_cycle7", {158'd0, busy, vector_op}, 160'd0);

        // SUB wrap, then SUB equal operands
        run(3'd1, 4'd5, pack5(0, 7, 8, 9, 10), pack5(1, 7, 8, 9, 10),
            1'b1, pack5(32'hFFFFFFFF, 0, 0, 0, 0), 1'b0, 1'b0);
        run(3'd1, 4'd6, pack5(9, 8, 7, 6, 5), pack5(9, 8, 7, 6, 5),
            1'b1, 160'd0, 1'b1, 1'b0);

        // DOT depends on build configuration
`ifdef VEXEC_DOT_EN
        run(3'd5, 4'd2, pack5(1, 2, 3, 4, 5), pack5(1, 1, 1, 1, 1),
            1'b1, pack5(15, 0, 0, 0, 0), 1'b0, 1'b0);
`else
        run(3'd5, 4'd2, pack5(1, 2, 3, 4, 5), pack5(1, 1, 1, 1, 1),
            1'b0, 160'd0, 1'b0, 1'b1);
`endif

        // MUL wrap to zero, MUL low-32 truncation
        run(3'd4, 4'd7, pack5(32'h00010000, 0, 0, 0, 0), pack5(32'h00010000, 0, 0, 0, 0),
            1'b1, 160'd0, 1'b1, 1'b0);
        run(3'd4, 4'd8, pack5(3, 32'hFFFFFFFF, 32'h00010000, 0, 7), pack5(5, 2, 32'h00010001, 9, 0),
            1'b1, pack5(15, 32'hFFFFFFFE, 32'h00010000, 0, 0), 1'b0, 1'b0);

        // AND / ORR, wa_in=15 passes through
        v_a = pack5(32'hF0F0F0F0, 32'h12345678, 0, 32'hFFFFFFFF, 1);
        v_b = pack5(32'hFF00FF00, 32'hFFFF0000, 32'hFFFFFFFF, 32'h0000FFFF, 1);
        run(3'd2, 4'd15, v_a, v_b, 1'b1,
            pack5(32'hF000F000, 32'h12340000, 0, 32'h0000FFFF, 1), 1'b0, 1'b0);
        run(3'd3, 4'd1, v_a, v_b, 1'b1,
            pack5(32'hFFF0FFF0, 32'hFFFF5678, 32'hFFFFFFFF, 32'hFFFFFFFF, 1), 1'b0, 1'b0);

        // Illegal opcodes
        run(3'd7, 4'd4, pack5(1, 2, 3, 4, 5), pack5(10, 20, 30, 40, 50), 1'b0, 160'd0, 1'b0, 1'b1);
        run(3'd6, 4'd9, pack5(0, 0, 0, 0, 0), pack5(0, 0, 0, 0, 0), 1'b0, 160'd0, 1'b0, 1'b1);

        // start in cycles 2 and 6 ignored, start in cycle 7 accepted
        @(negedge clk);
        issue(3'd0, 4'd10, pack5(1, 1, 1, 1, 1), pack5(2, 2, 2, 2, 2),
              1'b1, pack5(3, 3, 3, 3, 3), 1'b0, 1'b0);
        @(negedge clk);
        op = 3'd3; wa_in = 4'd11; a_vec = {5{32'hDEADBEEF}}; b_vec = {5{32'h1}}; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        issue(3'd1, 4'd12, pack5(100, 200, 300, 400, 500), pack5(1, 2, 3, 4, 5),
              1'b1, pack5(99, 198, 297, 396, 495), 1'b0, 1'b0);
        repeat (6) @(negedge clk);

        // Reset in cycle 3 aborts; then a fresh ADD completes
        @(negedge clk);
        op = 3'd0; wa_in = 4'd13; a_vec = pack5(1, 2, 3, 4, 5); b_vec = pack5(1, 2, 3, 4, 5); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_all_zero("reset_abort");
        repeat (8) @(negedge clk);
        run(3'd0, 4'd14, pack5(32'hFFFFFFFF, 5, 6, 7, 8), pack5(1, 5, 6, 7, 8),
            1'b1, pack5(0, 10, 12, 14, 16), 1'b0, 1'b0);

        repeat (10) @(negedge clk);
        check("scoreboard_drained", 160'(sb.size()), 160'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
